decode_reg_arith: RTL and testbench

- Decoder for RV32 R-type (OP, opcode 0110011) register-register arithmetic instructions.
- Maps funct3/funct7 to a reg_arith_kind_t operation kind for the execute stage.
- Provides a combinational kind/illegal result plus a one-cycle registered copy for pipelined consumers.
- Sits in the decode stage after opcode dispatch, one instance per decode lane.

---
 rtl/decode_reg_arith_pkg.sv | 50 +++++
 rtl/decode_reg_arith_if.sv | 23 ++
 rtl/decode_reg_arith_comb.sv | 76 +++++++
 rtl/decode_reg_arith.sv | 44 ++++
 tb/tb_decode_reg_arith.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/decode_reg_arith_pkg.sv
// Shared encodings for RV32 OP-opcode register-register arithmetic decode.
// Defines the operation kinds consumed by execute plus the funct3/funct7 field values.
package instr_type;

  typedef enum logic [4:0] {
    rak_add,
    rak_sub,
    rak_sll,
    rak_slt,
    rak_sltu,
    rak_xor,
    rak_srl,
    rak_sra,
    rak_or,
    rak_and,
    rak_mul,
    rak_mulh,
    rak_mulhsu,
    rak_mulhu,
    rak_div,
    rak_divu,
    rak_rem,
    rak_remu,
    rak_invalid
  } reg_arith_kind_t;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3 values shared by ADD/SUB and SRL/SRA; funct7 selects between them
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/decode_reg_arith_if.sv
// Bundle of decode-lane fields and decoded results for the R-type arithmetic decoder.
// The master side supplies funct fields; the slave side returns kind/illegal (comb and registered).
interface decode_reg_arith_if;
  import instr_type::*;

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  reg_arith_kind_t kind;
  logic            illegal;
  reg_arith_kind_t kind_q;
  logic            illegal_q;

  modport master (
    output funct3, funct7,
    input  kind, illegal, kind_q, illegal_q
  );

  modport slave (
    input  funct3, funct7,
    output kind, illegal, kind_q, illegal_q
  );

endinterface

// File: rtl/decode_reg_arith_comb.sv
// Pure combinational funct3/funct7 -> operation-kind table, reusable by other decoders.
// Optional RV32M group enabled by DECODE_REG_ARITH_M_EXT_EN.
module decode_reg_arith_comb
  import instr_type::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  output reg_arith_kind_t o_kind,
  output logic            o_illegal
);

  always_comb begin
    o_kind    = rak_invalid;
    o_illegal = 1'b1;
    // funct7 is matched on all seven bits; anything unlisted stays invalid
    case (i_funct7)
      FUNCT7_BASE: begin
        o_illegal = 1'b0;
        case (i_funct3)
          F3_ADD_SUB: o_kind = rak_add;
          F3_SLL:     o_kind = rak_sll;
          F3_SLT:     o_kind = rak_slt;
          F3_SLTU:    o_kind = rak_sltu;
          F3_XOR:     o_kind = rak_xor;
          F3_SRL_SRA: o_kind = rak_srl;
          F3_OR:      o_kind = rak_or;
          F3_AND:     o_kind = rak_and;
          default: begin
            o_kind    = rak_invalid;
            o_illegal = 1'b1;
          end
        endcase
      end
      FUNCT7_ALT: begin
        case (i_funct3)
          F3_ADD_SUB: begin
            o_kind    = rak_sub;
            o_illegal = 1'b0;
          end
          F3_SRL_SRA: begin
            o_kind    = rak_sra;
            o_illegal = 1'b0;
          end
          default: begin
            o_kind    = rak_invalid;
            o_illegal = 1'b1;
          end
        endcase
      end
`ifdef DECODE_REG_ARITH_M_EXT_EN
      FUNCT7_MULDIV: begin
        o_illegal = 1'b0;
        case (i_funct3)
          F3_MUL:    o_kind = rak_mul;
          F3_MULH:   o_kind = rak_mulh;
          F3_MULHSU: o_kind = rak_mulhsu;
          F3_MULHU:  o_kind = rak_mulhu;
          F3_DIV:    o_kind = rak_div;
          F3_DIVU:   o_kind = rak_divu;
          F3_REM:    o_kind = rak_rem;
          F3_REMU:   o_kind = rak_remu;
          default: begin
            o_kind    = rak_invalid;
            o_illegal = 1'b1;
          end
        endcase
      end
`endif
      default: begin
        o_kind    = rak_invalid;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_reg_arith.sv
// RV32 R-type arithmetic decoder: combinational kind/illegal plus a one-cycle registered copy.
// Build with DECODE_REG_ARITH_M_EXT_EN to accept the RV32M funct7=0000001 group.
module decode_reg_arith
  import instr_type::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output reg_arith_kind_t kind,
  output logic            illegal,
  output reg_arith_kind_t kind_q,
  output logic            illegal_q
);

  reg_arith_kind_t w_kind;
  logic            w_illegal;
  reg_arith_kind_t r_kind_q;
  logic            r_illegal_q;

  decode_reg_arith_comb u_comb (
    .i_funct3  (funct3),
    .i_funct7  (funct7),
    .o_kind    (w_kind),
    .o_illegal (w_illegal)
  );

  // Reset parks the pipeline copy as "no op" without flagging an exception
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind_q    <= rak_invalid;
      r_illegal_q <= 1'b0;
    end else begin
      r_kind_q    <= w_kind;
      r_illegal_q <= w_illegal;
    end
  end

  assign kind      = w_kind;
  assign illegal   = w_illegal;
  assign kind_q    = r_kind_q;
  assign illegal_q = r_illegal_q;

endmodule

// File: tb/tb_decode_reg_arith.sv
// Scoreboard bench for decode_reg_arith: directed vectors queue expected comb and registered
// results; a negedge monitor pops and compares them independently of the driver.
module tb_decode_reg_arith;
  import instr_type::*;

  typedef struct {
    int              idx;
    logic            rst;
    logic [2:0]      f3;
    logic [6:0]      f7;
    reg_arith_kind_t k;
    logic            ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  decode_reg_arith_if bus ();

  decode_reg_arith dut (
    .clk       (clk),
    .rst       (rst),
    .funct3    (bus.funct3),
    .funct7    (bus.funct7),
    .kind      (bus.kind),
    .illegal   (bus.illegal),
    .kind_q    (bus.kind_q),
    .illegal_q (bus.illegal_q)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  vec_t comb_q[$];
  vec_t reg_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   reg_ready = 1'b0;

  task automatic add_vec(input logic r, input logic [2:0] f3, input logic [6:0] f7,
                         input reg_arith_kind_t k, input logic ill);
    vec_t v;
    v.idx = vecs.size();
    v.rst = r;
    v.f3  = f3;
    v.f7  = f7;
    v.k   = k;
    v.ill = ill;
    vecs.push_back(v);
  endtask

  // Monitor: registered result of the previous vector, then comb result of the current one
  always @(negedge clk) begin
    vec_t e;
    if (reg_ready && reg_q.size() > 0) begin
      e = reg_q.pop_front();
      checks++;
      if (bus.kind_q !== e.k || bus.illegal_q !== e.ill) begin
        failures++;
        $display("FAIL reg[%0d] f7=%b f3=%b: got kind_q=%s illegal_q=%b, want kind_q=%s illegal_q=%b",
                 e.idx, e.f7, e.f3, bus.kind_q.name(), bus.illegal_q, e.k.name(), e.ill);
      end
    end
    if (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      checks++;
      if (bus.kind !== e.k || bus.illegal !== e.ill) begin
        failures++;
        $display("FAIL comb[%0d] f7=%b f3=%b: got kind=%s illegal=%b, want kind=%s illegal=%b",
                 e.idx, e.f7, e.f3, bus.kind.name(), bus.illegal, e.k.name(), e.ill);
      end else begin
        $display("txn %0d rst=%b f7=%b f3=%b kind=%s illegal=%b", e.idx, e.rst, e.f7, e.f3,
                 bus.kind.name(), bus.illegal);
      end
      reg_ready = 1'b1;
    end else begin
      reg_ready = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v, r;
    bus.funct3 = 3'b000;
    bus.funct7 = 7'b0000000;

    add_vec(1'b1, 3'b000, 7'b0000000, rak_add,  1'b0);
    add_vec(1'b0, 3'b000, 7'b0000000, rak_add,  1'b0);
    add_vec(1'b0, 3'b000, 7'b0100000, rak_sub,  1'b0);
    add_vec(1'b0, 3'b101, 7'b0100000, rak_sra,  1'b0);
    add_vec(1'b0, 3'b101, 7'b0000000, rak_srl,  1'b0);
    add_vec(1'b0, 3'b001, 7'b0000000, rak_sll,  1'b0);
    add_vec(1'b0, 3'b010, 7'b0000000, rak_slt,  1'b0);
    add_vec(1'b0, 3'b011, 7'b0000000, rak_sltu, 1'b0);
    add_vec(1'b0, 3'b100, 7'b0000000, rak_xor,  1'b0);
    add_vec(1'b0, 3'b110, 7'b0000000, rak_or,   1'b0);
    add_vec(1'b0, 3'b111, 7'b0000000, rak_and,  1'b0);
    add_vec(1'b0, 3'b010, 7'b0100000, rak_invalid, 1'b1);
    add_vec(1'b0, 3'b111, 7'b0100000, rak_invalid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      add_vec(1'b0, 3'(i), 7'b1111111, rak_invalid, 1'b1);
    end
    add_vec(1'b0, 3'b000, 7'b0100001, rak_invalid, 1'b1);
    add_vec(1'b0, 3'b000, 7'b0000010, rak_invalid, 1'b1);
    add_vec(1'b0, 3'b100, 7'b0000000, rak_xor,  1'b0);
    add_vec(1'b1, 3'b110, 7'b0000000, rak_or,   1'b0);
    add_vec(1'b0, 3'b111, 7'b0000000, rak_and,  1'b0);
    add_vec(1'b0, 3'b000, 7'b0100000, rak_sub,  1'b0);
`ifdef DECODE_REG_ARITH_M_EXT_EN
    add_vec(1'b0, 3'b100, 7'b0000001, rak_div,  1'b0);
    add_vec(1'b0, 3'b000, 7'b0000001, rak_mul,  1'b0);
    add_vec(1'b0, 3'b111, 7'b0000001, rak_remu, 1'b0);
`else
    add_vec(1'b0, 3'b100, 7'b0000001, rak_invalid, 1'b1);
    add_vec(1'b0, 3'b000, 7'b0000001, rak_invalid, 1'b1);
    add_vec(1'b0, 3'b111, 7'b0000001, rak_invalid, 1'b1);
`endif
    add_vec(1'b0, 3'b101, 7'b0000000, rak_srl,  1'b0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      rst        = v.rst;
      bus.funct3 = v.f3;
      bus.funct7 = v.f7;
      comb_q.push_back(v);
      r = v;
      if (v.rst) begin
        r.k   = rak_invalid;
        r.ill = 1'b0;
      end
      reg_q.push_back(r);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d comb and %0d reg entries pending, want 0 and 0",
               comb_q.size(), reg_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
